dshot_pwm_output: RTL and testbench
===================================

# dshot_pwm_output

Downstream stage of the DShot decoder: consumes each decoded frame (throttle, command flag, CRC status) and drives a standard servo/ESC PWM output. Enforces an arming sequence, clamps and scales throttle to pulse width, swaps pulse width only at PWM period boundaries, and falls back to a minimum-pulse failsafe when frames stop arriving. Sits between the DShot input decoder and the output pin.

## Interface
Parameters:
- PWM_PERIOD, 40000: PWM period in clk cycles (400 Hz at 16 MHz)
- MIN_PULSE, 16000: pulse width for zero throttle/stop, in cycles (1000 us)
- SCALE_SHIFT, 3: throttle left-shift into cycles (1 LSB = 8 cycles = 0.5 us)
- MAX_SPEED, 1999: throttle clamp value
- ARM_FRAMES, 10: consecutive command frames required to arm
- TIMEOUT_CYCLES, 1600000: frame-loss timeout in cycles (100 ms)

Ports:
- clk  in  1  system clock (16 MHz)
- rst_n  in  1  reset; **one clock; reset is synchronous and active-low**
- frameStrobe  in  1  single-cycle pulse: a new decoded frame is present on the inputs below
- setSpeed  in  11  decoded throttle (already offset by 48)
- isSpecialCommand  in  1  frame is a command, not a throttle value
- CRCValid  in  1  frame CRC matched
- pwmOut  out  1  PWM output, registered
- armed  out  1  high in ARMED
- failsafe  out  1  high in FAILSAFE

## Operation
- Valid frame = frameStrobe && CRCValid. frameStrobe with CRCValid=0 is ignored completely (no timer reload, no counter change).
- Command frame = valid && isSpecialCommand; speed frame = valid && !isSpecialCommand.
- Target pulse: speed frame -> MIN_PULSE + (min(setSpeed, MAX_SPEED) << SCALE_SHIFT); command frame -> MIN_PULSE. Compute in 16 bits; maximum 31992 at defaults. Parameter requirement: MIN_PULSE + (MAX_SPEED << SCALE_SHIFT) < PWM_PERIOD.
- States (2-bit):
  - DISARMED (reset): pending pulse forced to MIN_PULSE. Command frame increments armCount, which saturates at ARM_FRAMES. Speed frame or timeout clears armCount. When armCount reaches ARM_FRAMES -> ARMED, armCount cleared.
  - ARMED: each valid frame loads the pending pulse with the target pulse. Timeout -> FAILSAFE.
  - FAILSAFE: pending pulse forced to MIN_PULSE. Speed frames are ignored. The first command frame -> DISARMED with armCount=0; that frame does not count toward arming.
- Timeout counter: reloaded to 0 on every valid frame; otherwise increments and saturates. Timeout fires when the count reaches TIMEOUT_CYCLES-1. If a valid frame arrives in the same cycle, the frame wins and there is no timeout.
- PWM generator: periodCnt counts 0..PWM_PERIOD-1 and wraps. activePulse is loaded from the pending pulse when periodCnt==PWM_PERIOD-1. Between loads, activePulse never changes. pwmOut <= (next periodCnt < activePulse).
- The generator runs in all states, so a steady MIN_PULSE train is output when not armed.

## Timing
- Reset values: state DISARMED, armCount 0, timeout counter 0, periodCnt 0, pending and active pulse = MIN_PULSE, pwmOut 0, armed 0, failsafe 0.
- First clock with rst_n high: periodCnt advances, and pwmOut goes high from the next cycle.
- pwmOut high for exactly activePulse cycles per period; period is exactly PWM_PERIOD cycles.
- armed and failsafe are registered and reflect the state one cycle after the transition-causing event.
- Frame-to-pulse latency: the new width appears at the next period start, at most PWM_PERIOD+1 cycles after frameStrobe. A frame arriving in the cycle periodCnt==PWM_PERIOD-1 misses that load and applies one period later.
- Several frames within one period: only the last pending value takes effect, and no partial pulse is produced.
- rst_n low mid-pulse: pwmOut low on the next cycle; all state returns to reset values.

## Test plan
- Reset, no frames: pwmOut has a 40000-cycle period with exactly 16000 high cycles; armed=0, failsafe=0.
- Arming: 9 command frames then 1 speed frame (setSpeed=1000) -> stays DISARMED, pulse stays 16000. Then 10 command frames -> armed=1 one cycle after the 10th.
- Armed, speed frame setSpeed=1000 -> next full period high for 24000 cycles. setSpeed=2047 -> clamped to 31992. A frame with CRCValid=0 and setSpeed=500 -> width unchanged.
- Boundary: frame in cycle periodCnt==39999 -> the following period keeps the old width, and the one after uses the new width. Two frames in one period (200, then 400) -> only 19200 is applied.
- Timeout: armed, no frames for 1600000 cycles -> failsafe=1, armed=0, next period 16000. A frame in the expiry cycle prevents failsafe. Speed frame in FAILSAFE -> no change. Command frame -> DISARMED, then 10 more command frames re-arm.
- Reset asserted mid-pulse at width 31992 -> pwmOut 0 next cycle; after release the pulse is 16000 and the state is DISARMED.

Source files
------------

// File: rtl/dshot_frame_if.sv
// Decoded DShot frame bundle handed from the input decoder to the PWM output stage.
// frameStrobe is a single-cycle qualifier for the other three fields.
interface dshot_frame_if;
  logic        frameStrobe;
  logic [10:0] setSpeed;
  logic        isSpecialCommand;
  logic        CRCValid;

  modport master (
    output frameStrobe,
    output setSpeed,
    output isSpecialCommand,
    output CRCValid
  );

  modport slave (
    input frameStrobe,
    input setSpeed,
    input isSpecialCommand,
    input CRCValid
  );
endinterface

// File: rtl/dshot_pwm_output.sv
// DShot-to-PWM output stage: arming state machine, throttle clamp/scale,
// frame-loss failsafe and a period-synchronous PWM generator.
module dshot_pwm_output #(
  parameter int PWM_PERIOD     = 40000,
  parameter int MIN_PULSE      = 16000,
  parameter int SCALE_SHIFT    = 3,
  parameter int MAX_SPEED      = 1999,
  parameter int ARM_FRAMES     = 10,
  parameter int TIMEOUT_CYCLES = 1600000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dshot_frame_if.slave         frame_if,
  output logic                 pwmOut,
  output logic                 armed,
  output logic                 failsafe
);

  localparam int TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int ARMW = $clog2(ARM_FRAMES + 1);

  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]     PER_LAST   = 16'(PWM_PERIOD - 1);
  localparam logic [15:0]     MIN_W      = 16'(MIN_PULSE);
  localparam logic [10:0]     SPEED_MAX  = 11'(MAX_SPEED);
  localparam logic [ARMW-1:0] ARM_LAST   = ARMW'(ARM_FRAMES - 1);

  typedef enum logic [1:0] {
    S_DISARMED = 2'd0,
    S_ARMED    = 2'd1,
    S_FAILSAFE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [ARMW-1:0] arm_cnt_q, arm_cnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [15:0]     period_q, period_d;
  logic [15:0]     pending_q, pending_d;
  logic [15:0]     active_q, active_d;
  logic            pwm_q, pwm_d;
  logic            armed_q, armed_d;
  logic            failsafe_q, failsafe_d;

  logic            valid_frame, cmd_frame, speed_frame, timeout;
  logic [10:0]     speed_clamped;
  logic [15:0]     target_pulse;

  // Frame qualification, throttle clamp/scale and timeout detection.
  always_comb begin
    valid_frame   = frame_if.frameStrobe && frame_if.CRCValid;
    cmd_frame     = valid_frame && frame_if.isSpecialCommand;
    speed_frame   = valid_frame && !frame_if.isSpecialCommand;
    speed_clamped = (frame_if.setSpeed > SPEED_MAX) ? SPEED_MAX : frame_if.setSpeed;
    target_pulse  = frame_if.isSpecialCommand
                    ? MIN_W
                    : MIN_W + (16'(speed_clamped) << SCALE_SHIFT);
    // A frame in the expiry cycle wins over the timeout.
    timeout       = !valid_frame && (timer_q == TIMER_LAST);
  end

  // Arming state machine: next state and arm counter.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    case (state_q)
      S_DISARMED: begin
        if (cmd_frame) begin
          if (arm_cnt_q >= ARM_LAST) begin
            state_d   = S_ARMED;
            arm_cnt_d = '0;
          end else begin
            arm_cnt_d = arm_cnt_q + 1'b1;
          end
        end else if (speed_frame || timeout) begin
          arm_cnt_d = '0;
        end
      end
      S_ARMED: begin
        if (timeout) state_d = S_FAILSAFE;
      end
      S_FAILSAFE: begin
        // The recovering command frame does not count toward re-arming.
        if (cmd_frame) begin
          state_d   = S_DISARMED;
          arm_cnt_d = '0;
        end
      end
      default: begin
        state_d   = S_DISARMED;
        arm_cnt_d = '0;
      end
    endcase
  end

  // Timer, pending/active pulse, period counter and registered outputs.
  always_comb begin
    timer_d = valid_frame ? '0
            : (timer_q == TIMER_LAST) ? timer_q : timer_q + 1'b1;

    // Only ARMED lets a frame through; otherwise the pulse is pinned to minimum.
    if (state_d != S_ARMED)  pending_d = MIN_W;
    else if (valid_frame)    pending_d = target_pulse;
    else                     pending_d = pending_q;

    period_d   = (period_q == PER_LAST) ? 16'd0 : period_q + 16'd1;
    // Width swaps only at the period boundary so no partial pulse appears.
    active_d   = (period_q == PER_LAST) ? pending_q : active_q;
    pwm_d      = (period_d < active_d);
    armed_d    = (state_d == S_ARMED);
    failsafe_d = (state_d == S_FAILSAFE);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignment so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q    <= S_DISARMED;
      arm_cnt_q  <= '0;
      timer_q    <= '0;
      period_q   <= '0;
      pending_q  <= MIN_W;
      active_q   <= MIN_W;
      pwm_q      <= 1'b0;
      armed_q    <= 1'b0;
      failsafe_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      arm_cnt_q  <= arm_cnt_d;
      timer_q    <= timer_d;
      period_q   <= period_d;
      pending_q  <= pending_d;
      active_q   <= active_d;
      pwm_q      <= pwm_d;
      armed_q    <= armed_d;
      failsafe_q <= failsafe_d;
    end
  end

  assign pwmOut   = pwm_q;
  assign armed    = armed_q;
  assign failsafe = failsafe_q;

endmodule

// File: tb/tb_dshot_pwm_output.sv
// Directed bench for dshot_pwm_output with scaled-down parameters so the
// timeout and several PWM periods fit in a short run.
module tb_dshot_pwm_output;

  localparam int P    = 200;
  localparam int MINP = 50;
  localparam int SH   = 1;
  localparam int MAXS = 60;
  localparam int ARM  = 10;
  localparam int TO   = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pwm, armed, failsafe;

  dshot_frame_if frame_if ();

  dshot_pwm_output #(
    .PWM_PERIOD    (P),
    .MIN_PULSE     (MINP),
    .SCALE_SHIFT   (SH),
    .MAX_SPEED     (MAXS),
    .ARM_FRAMES    (ARM),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .frame_if(frame_if),
    .pwmOut  (pwm),
    .armed   (armed),
    .failsafe(failsafe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int speed;
    bit cmd;
    bit crc;
    int exp_hi;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present one frame for exactly one rising edge.
  task automatic send(input int spd, input bit cmd, input bit crc);
    frame_if.setSpeed         = 11'(spd);
    frame_if.isSpecialCommand = cmd;
    frame_if.CRCValid         = crc;
    frame_if.frameStrobe      = 1'b1;
    @(negedge clk);
    frame_if.frameStrobe      = 1'b0;
    frame_if.CRCValid         = 1'b0;
    frame_if.isSpecialCommand = 1'b0;
    frame_if.setSpeed         = '0;
  endtask

  // Advance to the next pwm rising edge (first high sample = period start).
  task automatic sync_rise(input string name);
    bit prev;
    bit got;
    got  = 1'b0;
    prev = pwm;
    for (int i = 0; i < 3 * P; i++) begin
      @(negedge clk);
      if (!prev && pwm) begin
        got = 1'b1;
        break;
      end
      prev = pwm;
    end
    check({name, "_sync"}, got, 1);
  endtask

  // Called at a period start; returns high count and period, ends at next start.
  task automatic measure(output int hi, output int per);
    bit prev;
    hi  = 0;
    per = 0;
    for (int i = 0; i < 3 * P; i++) begin
      prev = pwm;
      if (pwm) hi++;
      per++;
      @(negedge clk);
      if (!prev && pwm) break;
    end
  endtask

  task automatic check_period(input string name, input int exp_hi);
    int hi, per;
    measure(hi, per);
    check({name, "_high"}, hi, exp_hi);
    check({name, "_period"}, per, P);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int h, p, n;

    // MIN + (min(speed, MAXS) << SH)
    vecs[0] = '{30,   1'b0, 1'b1, 110};
    vecs[1] = '{200,  1'b0, 1'b1, 170};
    vecs[2] = '{10,   1'b0, 1'b0, 170};
    vecs[3] = '{60,   1'b0, 1'b1, 170};
    vecs[4] = '{0,    1'b0, 1'b1, 50};
    vecs[5] = '{45,   1'b1, 1'b1, 50};
    vecs[6] = '{61,   1'b0, 1'b1, 170};
    vecs[7] = '{2047, 1'b0, 1'b1, 170};

    frame_if.frameStrobe      = 1'b0;
    frame_if.setSpeed         = '0;
    frame_if.isSpecialCommand = 1'b0;
    frame_if.CRCValid         = 1'b0;

    // Reset state
    idle(5);
    check("rst_pwm", pwm, 0);
    check("rst_armed", armed, 0);
    check("rst_failsafe", failsafe, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_high", pwm, 1);
    sync_rise("idle");
    check_period("idle", MINP);

    // 9 commands then a speed frame: counter cleared, stays disarmed
    repeat (ARM - 1) send(0, 1'b1, 1'b1);
    send(30, 1'b0, 1'b1);
    check("disarm_speed_armed", armed, 0);
    sync_rise("disarmed");
    check_period("disarmed", MINP);

    for (int i = 0; i < ARM; i++) begin
      send(0, 1'b1, 1'b1);
      if (i == ARM - 2) check("arm_early", armed, 0);
    end
    check("arm_armed", armed, 1);
    check("arm_failsafe", failsafe, 0);

    // Throttle vectors, each applied one period after its frame
    sync_rise("vec_start");
    for (int i = 0; i < 8; i++) begin
      idle(20);
      send(vecs[i].speed, vecs[i].cmd, vecs[i].crc);
      sync_rise($sformatf("vec%0d", i));
      check_period($sformatf("vec%0d", i), vecs[i].exp_hi);
    end

    // Frame in the last cycle of a period misses that load
    idle(P - 1);
    send(20, 1'b0, 1'b1);
    check_period("boundary_old", 170);
    check_period("boundary_new", 90);

    // Two frames in one period: current period untouched, last one wins
    fork
      measure(h, p);
      begin
        idle(10);
        send(10, 1'b0, 1'b1);
        idle(10);
        send(30, 1'b0, 1'b1);
      end
    join
    check("two_frames_cur_high", h, 90);
    check("two_frames_cur_period", p, P);
    check_period("two_frames", 110);

    // Timeout: failsafe exactly TO cycles after the last frame
    send(30, 1'b0, 1'b1);
    n = 0;
    for (int i = 1; i <= TO + 50; i++) begin
      @(negedge clk);
      if (failsafe) begin
        n = i;
        break;
      end
    end
    check("timeout_cycles", n, TO);
    check("timeout_armed", armed, 0);
    sync_rise("failsafe");
    check_period("failsafe", MINP);

    // Speed frame ignored in failsafe
    send(30, 1'b0, 1'b1);
    check("fs_speed_failsafe", failsafe, 1);
    check("fs_speed_armed", armed, 0);
    sync_rise("fs_speed");
    check_period("fs_speed", MINP);

    // Command frame leaves failsafe without counting toward arming
    send(0, 1'b1, 1'b1);
    check("fs_cmd_failsafe", failsafe, 0);
    check("fs_cmd_armed", armed, 0);
    repeat (ARM - 1) send(0, 1'b1, 1'b1);
    check("rearm_early", armed, 0);
    send(0, 1'b1, 1'b1);
    check("rearm_armed", armed, 1);

    // Frame in the expiry cycle beats the timeout
    idle(TO - 1);
    send(30, 1'b0, 1'b1);
    check("race_failsafe", failsafe, 0);
    check("race_armed", armed, 1);
    idle(5);
    check("race_failsafe_late", failsafe, 0);
    sync_rise("race");
    check_period("race", 110);

    // Reset in the middle of a maximum-width pulse
    send(200, 1'b0, 1'b1);
    sync_rise("midrst");
    idle(100);
    check("midrst_before", pwm, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_pwm", pwm, 0);
    check("midrst_armed", armed, 0);
    check("midrst_failsafe", failsafe, 0);
    idle(3);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_first_high", pwm, 1);
    sync_rise("post_rst");
    check_period("post_rst", MINP);
    check("post_rst_armed", armed, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
